// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
//
// Groups the requester-side and bus-side signals of bus_arbiter.
//
// Handshake semantics (single statement for the whole bundle):
//   A requester raises *_req together with stable *_we/*_addr/*_wdata and holds
//   them until its one-cycle *_ack pulse, then drops req in the following
//   cycle. Read data (*_rdata) is valid with ack and held until the next ack
//   to that port. On the bus side the arbiter raises o_bus_clk with stable
//   o_bus_we/o_bus_addr/o_bus_data. The device answers with i_bus_data_ready,
//   and i_bus_data when the transfer is a read. The arbiter then drops the
//   strobe. The device must drop ready before the next strobe can start.
//
// Modports:
//   master : the arbiter (drives acks, rdata, err, owner and the bus outputs)
//   slave  : the environment (CPU/DMA requesters and the bus device)
// ---------------------------------------------------------------------------
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // requester side
  logic              i_cpu_req;
  logic              i_dma_req;
  logic              i_cpu_we;
  logic              i_dma_we;
  logic [ADDR_W-1:0] i_cpu_addr;
  logic [ADDR_W-1:0] i_dma_addr;
  logic [DATA_W-1:0] i_cpu_wdata;
  logic [DATA_W-1:0] i_dma_wdata;
  logic              o_cpu_ack;
  logic              o_dma_ack;
  logic [DATA_W-1:0] o_cpu_rdata;
  logic [DATA_W-1:0] o_dma_rdata;
  logic              o_err;
  logic              o_owner;
  // bus side
  logic              o_bus_clk;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [DATA_W-1:0] o_bus_data;
  logic [DATA_W-1:0] i_bus_data;
  logic              i_bus_data_ready;

  modport master (
    input  i_cpu_req, i_dma_req, i_cpu_we, i_dma_we,
    input  i_cpu_addr, i_dma_addr, i_cpu_wdata, i_dma_wdata,
    output o_cpu_ack, o_dma_ack, o_cpu_rdata, o_dma_rdata, o_err, o_owner,
    output o_bus_clk, o_bus_we, o_bus_addr, o_bus_data,
    input  i_bus_data, i_bus_data_ready
  );

  modport slave (
    output i_cpu_req, i_dma_req, i_cpu_we, i_dma_we,
    output i_cpu_addr, i_dma_addr, i_cpu_wdata, i_dma_wdata,
    input  o_cpu_ack, o_dma_ack, o_cpu_rdata, o_dma_rdata, o_err, o_owner,
    input  o_bus_clk, o_bus_we, o_bus_addr, o_bus_data,
    output i_bus_data, i_bus_data_ready
  );
endinterface

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Shares the 32-bit external memory bus between the CPU core and a DMA
// requester. It grants round-robin on ties and runs a strobe/ready handshake
// with a mandatory recover phase. It returns a one-cycle ack plus read data to
// the winner.
//
// Ports:
//   i_clk    clock, all state on the rising edge
//   i_rst_n  asynchronous active-low reset (drops the strobe immediately)
//   bus      bus_arbiter_if.master: requester req/we/addr/wdata in,
//            ack/rdata/err/owner out, o_bus_* strobe/address/data out,
//            i_bus_data/i_bus_data_ready in
//   o_state  debug view of the FSM (0 = IDLE, 1 = STROBE, 2 = RECOVER)
//
// Parameters: ADDR_W, DATA_W, TIMEOUT (strobe-wait limit, 8-bit counter).
//
// Optional feature: define BUS_ARB_TIMEOUT_EN to abort a strobe that has
// waited TIMEOUT cycles without ready (ack + o_err, read data forced to 0).
// Without it the strobe waits indefinitely and o_err is tied low.
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  bus_arbiter_if.master      bus,
  output logic [1:0]         o_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t state;
  logic   last_dma;   // priority pointer: 1 = DMA was granted last
  logic   grant_dma;

  // Single request wins outright; on a tie the port not granted last wins.
  assign grant_dma = bus.i_dma_req & (~bus.i_cpu_req | ~last_dma);

  assign o_state = state;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);
  logic [7:0] wait_cnt;
  logic       err_q;
  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= ST_IDLE;
      last_dma        <= 1'b1;
      bus.o_owner     <= 1'b0;
      bus.o_bus_clk   <= 1'b0;
      bus.o_bus_we    <= 1'b0;
      bus.o_bus_addr  <= '0;
      bus.o_bus_data  <= '0;
      bus.o_cpu_ack   <= 1'b0;
      bus.o_dma_ack   <= 1'b0;
      bus.o_cpu_rdata <= '0;
      bus.o_dma_rdata <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      wait_cnt        <= '0;
      err_q           <= 1'b0;
`endif
    end else begin
      // ack and err are single-cycle pulses
      bus.o_cpu_ack <= 1'b0;
      bus.o_dma_ack <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      err_q         <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (bus.i_cpu_req | bus.i_dma_req) begin
            bus.o_owner    <= grant_dma;
            bus.o_bus_we   <= grant_dma ? bus.i_dma_we    : bus.i_cpu_we;
            bus.o_bus_addr <= grant_dma ? bus.i_dma_addr  : bus.i_cpu_addr;
            bus.o_bus_data <= grant_dma ? bus.i_dma_wdata : bus.i_cpu_wdata;
            bus.o_bus_clk  <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
            state          <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (bus.i_bus_data_ready) begin
            bus.o_bus_clk <= 1'b0;
            if (!bus.o_bus_we) begin
              if (bus.o_owner) bus.o_dma_rdata <= bus.i_bus_data;
              else             bus.o_cpu_rdata <= bus.i_bus_data;
            end
            if (bus.o_owner) bus.o_dma_ack <= 1'b1;
            else             bus.o_cpu_ack <= 1'b1;
            last_dma      <= bus.o_owner;
            state         <= ST_RECOVER;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LIM) begin
            // abort: the requester still gets its ack, flagged by err
            bus.o_bus_clk <= 1'b0;
            if (!bus.o_bus_we) begin
              if (bus.o_owner) bus.o_dma_rdata <= '0;
              else             bus.o_cpu_rdata <= '0;
            end
            if (bus.o_owner) bus.o_dma_ack <= 1'b1;
            else             bus.o_cpu_ack <= 1'b1;
            err_q         <= 1'b1;
            last_dma      <= bus.o_owner;
            state         <= ST_RECOVER;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        ST_RECOVER: begin
          // no arbitration here: requesters get at least one cycle to drop req
          if (!bus.i_bus_data_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
